player_motion: RTL and testbench

- Per-player motion controller that produces the xpos_player/ypos_player pair consumed by the game-state controller (one instance per player).
- Converts button inputs into frame-rate horizontal motion and a fixed-profile jump, gated by the current g_state from state_pkg.
- Runs entirely in the clk_40 domain.

---
 rtl/player_motion.sv | 197 +++++++++++++++++++
 tb/tb_player_motion.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// player_motion: per-player horizontal motion and fixed-profile jump, clk_40 domain.
// Build option: define PLAYER_WRAP_EN to make horizontal motion wrap at
// X_MIN/X_MAX instead of saturating there. The default build saturates.
// Outputs carry no handshake: xpos_player/ypos_player/jumping are registered
// and valid on every cycle; consumers sample them whenever they like.
`timescale 1ns/1ps

package state_pkg;
    typedef enum logic [1:0] {
        START   = 2'd0,
        LEVEL_1 = 2'd1,
        FINISH  = 2'd2
    } g_state;
endpackage

module player_motion
    import state_pkg::*;
#(
    parameter int X_START     = 64,
    parameter int Y_GROUND    = 500,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 760,
    parameter int STEP        = 4,
    parameter int JUMP_HEIGHT = 96,
    parameter int JUMP_STEP   = 4,
    parameter int TICK_DIV    = 666667
)(
    input  logic        clk_40,
    input  logic        rst,
    input  g_state      game_state,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [11:0] xpos_player,
    output logic [11:0] ypos_player,
    output logic        jumping,
    output logic [1:0]  dbg_jump_state
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [11:0] X_START12  = 12'(X_START);
    localparam logic [11:0] Y_GROUND12 = 12'(Y_GROUND);
    localparam logic [11:0] Y_TOP12    = 12'(Y_GROUND - JUMP_HEIGHT);
    localparam logic [11:0] STEP12     = 12'(STEP);
    localparam logic [11:0] JSTEP12    = 12'(JUMP_STEP);
    localparam logic [11:0] X_LO_LIM   = 12'(X_MIN + STEP);
    localparam logic [11:0] X_HI_LIM   = 12'(X_MAX - STEP);

`ifdef PLAYER_WRAP_EN
    // Running off one edge reappears at the opposite edge.
    localparam logic [11:0] X_LEFT_EDGE  = 12'(X_MAX);
    localparam logic [11:0] X_RIGHT_EDGE = 12'(X_MIN);
`else
    // Running off an edge pins the player against that edge.
    localparam logic [11:0] X_LEFT_EDGE  = 12'(X_MIN);
    localparam logic [11:0] X_RIGHT_EDGE = 12'(X_MAX);
`endif

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } jump_state_t;

    logic             left_s1, left_s2;
    logic             right_s1, right_s2;
    logic             jump_s1, jump_s2, jump_prev;
    logic             jump_rise;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    jump_state_t      state_q, state_n;
    logic [11:0]      x_q, x_n;
    logic [11:0]      y_q, y_n;
    logic [11:0]      y_up, y_dn;
    logic             jump_req_q, jump_req_n;
    logic             jumping_q;

    assign jump_rise      = jump_s2 & ~jump_prev;
    assign tick           = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign xpos_player    = x_q;
    assign ypos_player    = y_q;
    assign jumping        = jumping_q;
    assign dbg_jump_state = state_q;

    // Two-flop synchronizers for the async buttons, plus a history flop for jump edge detect.
    always_ff @(posedge clk_40) begin
        if (!rst) begin
            left_s1   <= 1'b0;
            left_s2   <= 1'b0;
            right_s1  <= 1'b0;
            right_s2  <= 1'b0;
            jump_s1   <= 1'b0;
            jump_s2   <= 1'b0;
            jump_prev <= 1'b0;
        end else begin
            left_s1   <= btn_left;
            left_s2   <= left_s1;
            right_s1  <= btn_right;
            right_s2  <= right_s1;
            jump_s1   <= btn_jump;
            jump_s2   <= jump_s1;
            jump_prev <= jump_s2;
        end
    end

    // Free-running frame tick divider; counts in every game state.
    always_ff @(posedge clk_40) begin
        if (!rst || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // Next position, jump state and pending-jump flag from game state and buttons.
    always_comb begin
        x_n        = x_q;
        y_n        = y_q;
        state_n    = state_q;
        jump_req_n = jump_req_q;
        y_up       = y_q - JSTEP12;
        y_dn       = y_q + JSTEP12;

        case (game_state)
            START: begin
                x_n        = X_START12;
                y_n        = Y_GROUND12;
                state_n    = GROUND;
                jump_req_n = 1'b0;
            end
            LEVEL_1: begin
                // A press is only remembered while standing; it is consumed on take-off.
                if (jump_rise && state_q == GROUND) begin
                    jump_req_n = 1'b1;
                end
                if (tick) begin
                    if (left_s2 && !right_s2) begin
                        x_n = (x_q < X_LO_LIM) ? X_LEFT_EDGE : x_q - STEP12;
                    end else if (right_s2 && !left_s2) begin
                        x_n = (x_q > X_HI_LIM) ? X_RIGHT_EDGE : x_q + STEP12;
                    end

                    case (state_q)
                        GROUND: begin
                            if (jump_req_q) begin
                                y_n        = y_up;
                                state_n    = RISE;
                                jump_req_n = 1'b0;
                            end
                        end
                        RISE: begin
                            if (y_up <= Y_TOP12) begin
                                y_n     = Y_TOP12;
                                state_n = FALL;
                            end else begin
                                y_n = y_up;
                            end
                        end
                        FALL: begin
                            if (y_dn >= Y_GROUND12) begin
                                y_n     = Y_GROUND12;
                                state_n = GROUND;
                            end else begin
                                y_n = y_dn;
                            end
                        end
                        default: state_n = GROUND;
                    endcase
                end
            end
            default: begin
                // FINISH and unencoded states freeze motion; a stale press is dropped.
                jump_req_n = 1'b0;
            end
        endcase
    end

    // Motion and jump state registers; jumping is registered alongside the state.
    always_ff @(posedge clk_40) begin
        if (!rst) begin
            x_q        <= X_START12;
            y_q        <= Y_GROUND12;
            state_q    <= GROUND;
            jump_req_q <= 1'b0;
            jumping_q  <= 1'b0;
        end else begin
            x_q        <= x_n;
            y_q        <= y_n;
            state_q    <= state_n;
            jump_req_q <= jump_req_n;
            jumping_q  <= (state_n != GROUND);
        end
    end

endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: random button/game-state stimulus against a tick-level
// behavioural model; a monitor compares registered outputs every cycle.
`timescale 1ns/1ps

module tb_player_motion;
    import state_pkg::*;

    localparam int TD          = 4;
    localparam int X_START     = 64;
    localparam int Y_GROUND    = 500;
    localparam int X_MIN       = 0;
    localparam int X_MAX       = 760;
    localparam int STEP        = 4;
    localparam int JUMP_HEIGHT = 96;
    localparam int JUMP_STEP   = 4;
    localparam int UP_TICKS    = JUMP_HEIGHT / JUMP_STEP;
    localparam int AIR_TICKS   = 2 * UP_TICKS;

    // ---------------- clock / reset / DUT ----------------
    logic        clk_40 = 1'b0;
    logic        rst = 1'b0;
    g_state      game_state = START;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_jump = 1'b0;
    logic [11:0] xpos_player;
    logic [11:0] ypos_player;
    logic        jumping;
    logic [1:0]  dbg_jump_state;

    always #5 clk_40 = ~clk_40;

    player_motion #(
        .X_START(X_START), .Y_GROUND(Y_GROUND), .X_MIN(X_MIN), .X_MAX(X_MAX),
        .STEP(STEP), .JUMP_HEIGHT(JUMP_HEIGHT), .JUMP_STEP(JUMP_STEP), .TICK_DIV(TD)
    ) dut (
        .clk_40(clk_40),
        .rst(rst),
        .game_state(game_state),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_jump(btn_jump),
        .xpos_player(xpos_player),
        .ypos_player(ypos_player),
        .jumping(jumping),
        .dbg_jump_state(dbg_jump_state)
    );

    // ---------------- scoreboard ----------------
    logic [24:0] exp_q[$];   // {jumping, x[11:0], y[11:0]}
    int          checks = 0;
    int          failures = 0;
    bit          stim_done = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Position in the jump is a tick count into the airborne profile (0 = standing).
    int       m_x, m_jt, m_cyc;
    bit       m_pend;
    bit [2:0] h_left, h_right, h_jump;   // [0]=driven 1 edge ago, [1]=2 ago, [2]=3 ago

    function automatic int jump_y(input int jt);
        if (jt == 0)              return Y_GROUND;
        else if (jt <= UP_TICKS)  return Y_GROUND - JUMP_STEP * jt;
        else                      return Y_GROUND - JUMP_STEP * (AIR_TICKS - jt);
    endfunction

    task automatic model_edge();
        bit tick, l, r, rise, pend_next;
        if (!rst) begin
            m_x = X_START; m_jt = 0; m_pend = 1'b0; m_cyc = 0;
            h_left = '0; h_right = '0; h_jump = '0;
        end else begin
            tick  = (m_cyc % TD) == (TD - 1);
            m_cyc = m_cyc + 1;
            // Buttons reach the logic two edges after they are driven.
            l    = h_left[1];
            r    = h_right[1];
            rise = h_jump[1] && !h_jump[2];
            if (game_state == START) begin
                m_x = X_START; m_jt = 0; m_pend = 1'b0;
            end else if (game_state == LEVEL_1) begin
                pend_next = m_pend || (rise && m_jt == 0);
                if (tick) begin
                    if (l && !r) begin
                        if (m_x - STEP < X_MIN)
`ifdef PLAYER_WRAP_EN
                            m_x = X_MAX;
`else
                            m_x = X_MIN;
`endif
                        else m_x = m_x - STEP;
                    end else if (r && !l) begin
                        if (m_x + STEP > X_MAX)
`ifdef PLAYER_WRAP_EN
                            m_x = X_MIN;
`else
                            m_x = X_MAX;
`endif
                        else m_x = m_x + STEP;
                    end
                    if (m_jt == 0) begin
                        if (m_pend) begin
                            m_jt = 1;
                            pend_next = 1'b0;
                        end
                    end else begin
                        m_jt = (m_jt + 1 == AIR_TICKS) ? 0 : m_jt + 1;
                    end
                end
                m_pend = pend_next;
            end else begin
                m_pend = 1'b0;
            end
            h_left  = {h_left[1:0], btn_left};
            h_right = {h_right[1:0], btn_right};
            h_jump  = {h_jump[1:0], btn_jump};
        end
        exp_q.push_back({(m_jt != 0), 12'(m_x), 12'(jump_y(m_jt))});
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit r, input g_state gs, input bit l, input bit rt, input bit j);
        @(negedge clk_40);
        rst        = r;
        game_state = gs;
        btn_left   = l;
        btn_right  = rt;
        btn_jump   = j;
        model_edge();
    endtask

    task automatic run(input int n, input g_state gs, input bit l, input bit rt, input int jump_mode);
        bit j;
        for (int i = 0; i < n; i++) begin
            case (jump_mode)
                0: j = 1'b0;
                1: j = 1'b1;
                default: j = ($urandom_range(0, 15) == 0) ? ~btn_jump : btn_jump;
            endcase
            drive(1'b1, gs, l, rt, j);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [24:0] e;
        forever begin
            @(posedge clk_40);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("xpos", int'(xpos_player), int'(e[23:12]));
                check("ypos", int'(ypos_player), int'(e[11:0]));
                check("jumping", int'(jumping), int'(e[24]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        g_state gs;
        int     len;
        bit     l, rt, j;

        // Reset, then START: spawn values held whatever the buttons do.
        for (int i = 0; i < 3; i++) drive(1'b0, START, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) drive(1'b1, START, 1'($urandom), 1'($urandom), 1'($urandom));

        // Run right into the right edge, then left into the left edge, with jump taps.
        run(800, LEVEL_1, 1'b0, 1'b1, 2);
        run(900, LEVEL_1, 1'b1, 1'b0, 2);
        run(40, LEVEL_1, 1'b1, 1'b1, 0);

        // Hold jump for 100 ticks, release, press again.
        run(400, LEVEL_1, 1'b0, 1'b0, 1);
        run(8, LEVEL_1, 1'b0, 1'b0, 0);
        run(240, LEVEL_1, 1'b0, 1'b1, 1);

        // Freeze mid-jump, then respawn.
        run(8, LEVEL_1, 1'b0, 1'b0, 0);
        run(50, LEVEL_1, 1'b0, 1'b0, 1);
        run(80, FINISH, 1'b1, 1'b0, 0);
        run(6, START, 1'b0, 1'b0, 0);

        // Reset pulse mid-jump while in LEVEL_1.
        run(6, LEVEL_1, 1'b0, 1'b0, 0);
        run(60, LEVEL_1, 1'b0, 1'b1, 1);
        drive(1'b0, LEVEL_1, 1'b0, 1'b1, 1'b1);
        run(40, LEVEL_1, 1'b0, 1'b1, 0);

        // Random segments across all game states, including an unencoded one.
        for (int s = 0; s < 50; s++) begin
            case ($urandom_range(0, 9))
                0:       gs = START;
                1:       gs = FINISH;
                2:       gs = g_state'(2'd3);
                default: gs = LEVEL_1;
            endcase
            len = $urandom_range(20, 300);
            if ($urandom_range(0, 9) == 0) drive(1'b0, gs, 1'b0, 1'b0, 1'b0);
            l = btn_left; rt = btn_right; j = btn_jump;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 39) == 0) l  = ~l;
                if ($urandom_range(0, 39) == 0) rt = ~rt;
                if ($urandom_range(0, 19) == 0) j  = ~j;
                drive(1'b1, gs, l, rt, j);
            end
        end

        run(4, LEVEL_1, 1'b0, 1'b0, 0);
        stim_done = 1'b1;
    end

    // ---------------- report ----------------
    initial begin
        wait (stim_done);
        repeat (3) @(posedge clk_40);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: stimulus is finite, this only guards against a stuck run.
    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
